// File: rtl/montgomery_mul_param.sv
// Montgomery modular multiplier: result = A*B*2^-WIDTH mod M.
// DIGITS bits of A are folded into a carry-save accumulator per MUL cycle,
// then resolved by a carry-propagate add and, when MONT_FULL_REDUCE_EN is
// defined, a single conditional subtract of M. Without the macro the SUB state
// is skipped and result < 2M (caller must guarantee 2M <= 2^WIDTH).
module montgomery_mul_param #(
  parameter int unsigned WIDTH  = 1024,
  parameter int unsigned DIGITS = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N  = WIDTH / DIGITS;
  localparam int unsigned CW = $clog2(N + 1);
  // Headroom so no intermediate carry-save term can overflow before the halving.
  localparam int unsigned XW = WIDTH + 3;

  typedef enum logic [1:0] {StIdle, StMul, StAdd, StSub} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic [WIDTH:0]   s_q, c_q;
  logic [CW-1:0]    cnt_q;

  logic [XW-1:0] s_w, c_w, bx, s1, c1, qm, s2, c2;
  logic [WIDTH:0] sum;
  logic unused_bits;

  // DIGITS chained radix-2 Montgomery steps in carry-save form.
  always_comb begin
    s_w = {2'b00, s_q};
    c_w = {2'b00, c_q};
    bx  = '0;
    s1  = '0;
    c1  = '0;
    qm  = '0;
    s2  = '0;
    c2  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bx = a_q[i] ? {3'b000, b_q} : '0;
      s1 = s_w ^ c_w ^ bx;
      c1 = ((s_w & c_w) | (s_w & bx) | (c_w & bx)) << 1;
      // c1[0] is always 0, so the parity of the partial sum is s1[0].
      qm = s1[0] ? {3'b000, m_q} : '0;
      s2 = s1 ^ c1 ^ qm;
      c2 = ((s1 & c1) | (s1 & qm) | (c1 & qm)) << 1;
      // Total is even for odd M, so both vectors halve exactly.
      s_w = s2 >> 1;
      c_w = c2 >> 1;
    end
  end

  assign sum = s_q + c_q;

`ifdef MONT_FULL_REDUCE_EN
  logic [WIDTH:0] r_q;
  logic [WIDTH:0] diff;
  assign diff        = r_q - {1'b0, m_q};
  assign unused_bits = ^{s_w[XW-1:WIDTH+1], c_w[XW-1:WIDTH+1], diff[WIDTH]};
`else
  assign unused_bits = ^{s_w[XW-1:WIDTH+1], c_w[XW-1:WIDTH+1], sum[WIDTH]};
`endif

  // Control FSM with registered outputs and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MONT_FULL_REDUCE_EN
      r_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= in_a;
            b_q     <= in_b;
            m_q     <= in_m;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StMul;
          end
        end
        StMul: begin
          a_q   <= a_q >> DIGITS;
          s_q   <= s_w[WIDTH:0];
          c_q   <= c_w[WIDTH:0];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_q <= StAdd;
        end
        StAdd: begin
`ifdef MONT_FULL_REDUCE_EN
          r_q     <= sum;
          state_q <= StSub;
`else
          result  <= sum[WIDTH-1:0];
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
`endif
        end
        StSub: begin
`ifdef MONT_FULL_REDUCE_EN
          result <= (r_q >= {1'b0, m_q}) ? diff[WIDTH-1:0] : r_q[WIDTH-1:0];
          done   <= 1'b1;
`endif
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
